dat_rx_deser: RTL
=================

// Module: dat_rx_deser
// PURPOSE
//  Read-path DAT stage. Captures card->host data blocks on 4-bit DAT, strips start/CRC/end bits and packs
//  nibbles into FIFO_WIDTH words. Writes the words into the Rx FIFO. Sits between the SD DAT pins and
//  the Rx FIFO, in parallel with the write-path DAT stage. Reports per-transfer status to DAT control.
// PARAMETERS
//  FIFO_WIDTH       32   Rx FIFO word width, bits; multiple of 8
//  BLOCK_SZ_WIDTH   12   block_sz width (bytes per block)
//  BLOCK_CNT_WIDTH  16   block_cnt width
//  TOUT_WIDTH       16   timeout_cycles width
// PORTS
//  sd_clk          in   1                SD clock; all logic samples on posedge
//  rst             in   1                reset, asynchronous, active-high
//  DAT_din         in   4                DAT[3:0] from card
//  read_flag       in   1                level; rising edge starts a transfer, low aborts it
//  block_sz        in   BLOCK_SZ_WIDTH   bytes per block; sampled at start
//  block_cnt       in   BLOCK_CNT_WIDTH  blocks per transfer; sampled at start
//  timeout_cycles  in   TOUT_WIDTH       max sd_clk cycles to wait for a start bit
//  rx_buf_full     in   1                Rx FIFO full
//  rx_buf_wr_enb   out  1                one-cycle write strobe to Rx FIFO
//  rx_buf_din_out  out  FIFO_WIDTH       word to Rx FIFO; valid only while rx_buf_wr_enb=1
//  rx_busy         out  1                high whenever state != IDLE
//  tf_finished     out  1                one-cycle pulse at end of transfer (normal or error)
//  crc_err, end_err, timeout_err, overrun_err  out 1 each  sticky; cleared on next start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Asserting rst mid-transfer aborts immediately; no tf_finished.
//  Start: read_flag rising edge in IDLE latches block_sz and block_cnt, clears the error flags, and moves to WAIT_START.
//    If block_cnt==0 or block_sz==0: pulse tf_finished and stay in IDLE.
//  FSM:
//    IDLE -> WAIT_START
//    WAIT_START: DAT_din==4'h0 -> DATA.
//      The timeout counter reaching timeout_cycles first -> timeout_err=1, tf_finished, IDLE.
//    DATA: one nibble per cycle, MSB-first into the word: the first nibble lands in bits [FW-1:FW-4].
//      After FIFO_WIDTH/4 nibbles, rx_buf_wr_enb=1 on the next cycle (latency 1 from the last nibble).
//      After 2*block_sz nibbles -> CRC. A final partial word is written left-aligned and zero-padded.
//    CRC: 16 cycles, one bit per lane per cycle -> END.
//    END: expects DAT_din==4'hF; any low lane sets end_err.
//      Then block counter-1. If the counter is still >0 -> WAIT_START with the timeout reset; else tf_finished, IDLE.
//  Overrun: word complete while rx_buf_full=1 -> word dropped, no strobe, overrun_err=1; transfer continues.
//    The card clock is never stopped.
//  Abort: read_flag=0 in any non-IDLE state -> IDLE next cycle; no strobe, no tf_finished, errors kept.
//  Simultaneous: abort beats a word write in the same cycle; tf_finished and the last word strobe may coincide.
//  Counters: the nibble counter is BLOCK_SZ_WIDTH+1 bits wide, so 2*max block_sz does not wrap.
//    The timeout counter saturates.
// CONFIGURATION
//  DAT_RX_CRC_CHK_EN defined:
//    - Four CRC16 units, CCITT x^16+x^12+x^5+1, init 0, one per lane, fed during DATA.
//    - In CRC state, received bits are compared to the computed CRC; any mismatch sets crc_err.
//  Not defined:
//    - The CRC state only counts 16 cycles.
//    - crc_err is tied 0 and no CRC logic is instantiated.
// STRUCTURE
//  Shared defines (defines.v): FIFO_WIDTH, BLOCK_SZ_WIDTH, BLOCK_CNT_WIDTH, CRC16 polynomial constant,
//    DAT start/end nibble constants.
//  Local to this module: one-hot state encoding IDLE/WAIT_START/DATA/CRC/END.
//  Sub-module dat_crc16_line: serial 1-bit CRC16 with clr/en inputs; 4 instances under DAT_RX_CRC_CHK_EN.
// TESTING
//  1. block_sz=8, block_cnt=1, start after 3 idle cycles, nibbles 0x0123456789ABCDEF
//     -> words 0x01234567 then 0x89ABCDEF, one tf_finished, no errors.
//  2. block_sz=4, block_cnt=3, 5-cycle gap between blocks
//     -> 3 strobes, tf_finished once after the third end bit.
//  3. timeout_cycles=10, DAT held 4'hF
//     -> timeout_err=1 and tf_finished on cycle 10, no strobe.
//  4. CRC_EN build, lane 2 CRC bit 7 flipped -> crc_err=1, data still written.
//     Non-CRC build, same stimulus -> crc_err=0.
//  5. rx_buf_full=1 during the 2nd word of case 1 -> only 0x01234567 written, overrun_err=1.
//  6. read_flag dropped mid-DATA, and in a separate run rst asserted mid-DATA
//     -> IDLE, no tf_finished; a new start then transfers cleanly.

Source files
------------

// File: rtl/dat_rx_deser_pkg.sv
// dat_rx_deser_pkg: shared widths, DAT framing nibbles and the CRC16-CCITT step for the read-path DAT stage.
package dat_rx_deser_pkg;
  localparam int DEF_FIFO_WIDTH = 32;
  localparam int DEF_BLOCK_SZ_WIDTH = 12;
  localparam int DEF_BLOCK_CNT_WIDTH = 16;
  localparam int DEF_TOUT_WIDTH = 16;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [3:0] DAT_START = 4'h0;
  localparam logic [3:0] DAT_END = 4'hF;
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? CRC16_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/dat_rx_deser_crc16.sv
// dat_crc16_line: serial one-bit CRC16-CCITT (init 0) with synchronous clear and enable.
module dat_crc16_line
  import dat_rx_deser_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);
  always_ff @(posedge clk or posedge rst)
    if (rst) crc_o <= '0;
    else if (clr_i) crc_o <= '0;
    else if (en_i) crc_o <= crc16_step(crc_o, bit_i);
endmodule

// File: rtl/dat_rx_deser.sv
// dat_rx_deser: SD read-path DAT stage; deframes 4-bit blocks into Rx FIFO words.
// Define DAT_RX_CRC_CHK_EN to check the per-lane CRC16 against the received CRC bits.
module dat_rx_deser
  import dat_rx_deser_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int BLOCK_SZ_WIDTH = DEF_BLOCK_SZ_WIDTH,
  parameter int BLOCK_CNT_WIDTH = DEF_BLOCK_CNT_WIDTH,
  parameter int TOUT_WIDTH = DEF_TOUT_WIDTH
) (
  input  logic                       sd_clk,
  input  logic                       rst,
  input  logic [3:0]                 DAT_din,
  input  logic                       read_flag,
  input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
  input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
  input  logic [TOUT_WIDTH-1:0]      timeout_cycles,
  input  logic                       rx_buf_full,
  output logic                       rx_buf_wr_enb,
  output logic [FIFO_WIDTH-1:0]      rx_buf_din_out,
  output logic                       rx_busy,
  output logic                       tf_finished,
  output logic                       crc_err,
  output logic                       end_err,
  output logic                       timeout_err,
  output logic                       overrun_err
);
  localparam int NPW = FIFO_WIDTH / 4;
  localparam int PW = $clog2(NPW);
  typedef enum logic [4:0] {
    IDLE = 5'b00001, WAIT_START = 5'b00010, DATA = 5'b00100, CRC = 5'b01000, END = 5'b10000
  } state_t;
  state_t state_q;
  logic rf_q;
  logic [BLOCK_SZ_WIDTH-1:0] bsz_q;
  logic [BLOCK_CNT_WIDTH-1:0] bcnt_q;
  logic [BLOCK_SZ_WIDTH:0] nib_q;
  logic [PW-1:0] pos_q;
  logic [FIFO_WIDTH-1:0] word_q, word_d;
  logic [3:0] crc_cnt_q;
  logic [TOUT_WIDTH-1:0] tout_q, tout_d;
  logic last_nib, word_done, start;
  // a new word starts from zero so a short final word comes out left-aligned and zero-padded
  assign word_d = (pos_q == '0 ? '0 : word_q) | ({DAT_din, {(FIFO_WIDTH-4){1'b0}}} >> {pos_q, 2'b00});
  assign last_nib = nib_q == {bsz_q, 1'b0} - (BLOCK_SZ_WIDTH+1)'(1);
  assign word_done = state_q == DATA && (last_nib || pos_q == PW'(NPW-1));
  assign tout_d = tout_q + {{(TOUT_WIDTH-1){1'b0}}, ~&tout_q};
  assign start = state_q == IDLE && read_flag && !rf_q;
  assign rx_busy = state_q != IDLE;
`ifdef DAT_RX_CRC_CHK_EN
  logic [15:0] crc_q [4];
  logic [3:0] crc_exp;
  for (genvar i = 0; i < 4; i++) begin : g_crc
    dat_crc16_line u_crc (
      .clk(sd_clk), .rst(rst), .clr_i(state_q == WAIT_START), .en_i(state_q == DATA),
      .bit_i(DAT_din[i]), .crc_o(crc_q[i])
    );
    assign crc_exp[i] = crc_q[i][~crc_cnt_q];
  end
`else
  assign crc_err = 1'b0;
`endif
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rf_q <= 1'b0;
      bsz_q <= '0;
      bcnt_q <= '0;
      nib_q <= '0;
      pos_q <= '0;
      word_q <= '0;
      crc_cnt_q <= '0;
      tout_q <= '0;
      rx_buf_wr_enb <= 1'b0;
      rx_buf_din_out <= '0;
      tf_finished <= 1'b0;
      end_err <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef DAT_RX_CRC_CHK_EN
      crc_err <= 1'b0;
`endif
    end else begin
      rf_q <= read_flag;
      rx_buf_wr_enb <= 1'b0;
      tf_finished <= 1'b0;
      if (state_q != IDLE && !read_flag) state_q <= IDLE;
      else case (state_q)
        IDLE: if (start) begin
          bsz_q <= block_sz;
          bcnt_q <= block_cnt;
          tout_q <= '0;
          end_err <= 1'b0;
          timeout_err <= 1'b0;
          overrun_err <= 1'b0;
`ifdef DAT_RX_CRC_CHK_EN
          crc_err <= 1'b0;
`endif
          if (block_sz == '0 || block_cnt == '0) tf_finished <= 1'b1;
          else state_q <= WAIT_START;
        end
        WAIT_START: if (DAT_din == DAT_START) begin
          state_q <= DATA;
          nib_q <= '0;
          pos_q <= '0;
        end else begin
          tout_q <= tout_d;
          if (tout_d >= timeout_cycles) begin
            timeout_err <= 1'b1;
            tf_finished <= 1'b1;
            state_q <= IDLE;
          end
        end
        DATA: begin
          word_q <= word_d;
          nib_q <= nib_q + (BLOCK_SZ_WIDTH+1)'(1);
          pos_q <= word_done ? '0 : pos_q + PW'(1);
          if (word_done && rx_buf_full) overrun_err <= 1'b1;
          if (word_done && !rx_buf_full) begin
            rx_buf_wr_enb <= 1'b1;
            rx_buf_din_out <= word_d;
          end
          if (last_nib) begin
            state_q <= CRC;
            crc_cnt_q <= '0;
          end
        end
        CRC: begin
          crc_cnt_q <= crc_cnt_q + 4'd1;
`ifdef DAT_RX_CRC_CHK_EN
          if (DAT_din != crc_exp) crc_err <= 1'b1;
`endif
          if (&crc_cnt_q) state_q <= END;
        end
        END: begin
          if (DAT_din != DAT_END) end_err <= 1'b1;
          bcnt_q <= bcnt_q - BLOCK_CNT_WIDTH'(1);
          if (bcnt_q == BLOCK_CNT_WIDTH'(1)) begin
            tf_finished <= 1'b1;
            state_q <= IDLE;
          end else begin
            tout_q <= '0;
            state_q <= WAIT_START;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
